// File: rtl/oka_pkg.sv
// Shared state type, default sizes and the overlap-free recombination
// used by the folded Karatsuba GF(2)[x] multiplier.
package oka_pkg;

   // Default operand width and the derived half/half-product widths.
   localparam int OKA_N = 36;
   localparam int H     = OKA_N / 2;
   localparam int PW    = OKA_N - 1;

   // Widest operand the generic recombine function is sized for.
   localparam int MAX_N = 64;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL0 = 3'd1,
      MUL1 = 3'd2,
      MUL2 = 3'd3,
      DONE = 3'd4
   } oka_state_t;

   // Half products and full product, padded to the widest supported N.
   typedef logic [MAX_N-2:0]   oka_half_prod_t;
   typedef logic [2*MAX_N-2:0] oka_prod_t;

   // Interleave the three half products into the full product.
   // Even bit 2i collects P0[i] and P1[i-1]; odd bit 2i+1 is P2^P0^P1 at i.
   // Only the lowest n-1 half-product bits are meaningful, so n bounds
   // the loop; the caller passes its own N as a constant.
   function automatic oka_prod_t recombine(
      input oka_half_prod_t p0,
      input oka_half_prod_t p1,
      input oka_half_prod_t p2,
      input int             n
   );
      oka_prod_t r;
      r = '0;
      for (int i = 0; i < MAX_N - 1; i++) begin
         if (i < n - 1) begin
            r[2*i]     = r[2*i] ^ p0[i];
            r[2*i + 1] = p2[i] ^ p0[i] ^ p1[i];
            r[2*i + 2] = r[2*i + 2] ^ p1[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/oka_seq_mult_clmul_half.sv
// Combinational W x W carry-less schoolbook multiplier (2W-1 bit result).
// Kept as its own block so it can be replaced by a combinational OKA tree
// of the same width without touching the sequencer.
module clmul_half #(
   parameter int W = 18
) (
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic [2*W-2:0] o_p
);

   logic [2*W-2:0] w_rows [W];

   // One partial-product row per multiplier bit: a shifted by the bit index.
   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_row
         assign w_rows[gi] = i_b[gi] ? ({{(W-1){1'b0}}, i_a} << gi) : '0;
      end
   endgenerate

   // XOR-accumulate the rows (GF(2) addition, no carries).
   always_comb begin
      o_p = '0;
      for (int i = 0; i < W; i++) begin
         o_p = o_p ^ w_rows[i];
      end
   end

endmodule

// File: rtl/oka_seq_mult.sv
// Folded overlap-free Karatsuba GF(2)[x] multiplier. The three half products
// P0=Ae*Be, P1=Ao*Bo, P2=(Ae^Ao)*(Be^Bo) are formed one per cycle on a single
// half-width carry-less multiplier, then interleaved into a registered
// 2N-1 bit product. Valid/ready handshakes on input and output.
module oka_seq_mult
   import oka_pkg::*;
#(
   parameter int N = OKA_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-2:0] y
);

   localparam int HN = N / 2;
   localparam int PN = N - 1;

   generate
      if ((N % 2) != 0 || N < 4 || N > MAX_N) begin : g_bad_n
         $error("oka_seq_mult: N must be even, at least 4 and at most MAX_N");
      end
   endgenerate

   oka_state_t       r_state;
   oka_state_t       w_state_next;

   logic [N-1:0]     r_a;
   logic [N-1:0]     r_b;
   logic [PN-1:0]    r_p0;
   logic [PN-1:0]    r_p1;
   logic [2*N-2:0]   r_y;

   logic             w_load;
   logic             w_cap_p0;
   logic             w_cap_p1;
   logic             w_cap_y;

   logic [HN-1:0]    w_ae;
   logic [HN-1:0]    w_ao;
   logic [HN-1:0]    w_be;
   logic [HN-1:0]    w_bo;
   logic [HN-1:0]    w_mul_a;
   logic [HN-1:0]    w_mul_b;
   logic [PN-1:0]    w_mul_p;

   oka_half_prod_t   w_p0_ext;
   oka_half_prod_t   w_p1_ext;
   oka_half_prod_t   w_p2_ext;
   oka_prod_t        w_y_full;
   logic [2*N-2:0]   w_y_next;
   logic             w_unused_y_hi;

   // Even/odd coefficient split of the registered operands.
   genvar gi;
   generate
      for (gi = 0; gi < HN; gi++) begin : g_split
         assign w_ae[gi] = r_a[2*gi];
         assign w_ao[gi] = r_a[2*gi + 1];
         assign w_be[gi] = r_b[2*gi];
         assign w_bo[gi] = r_b[2*gi + 1];
      end
   endgenerate

   // Select which half-product pair feeds the shared multiplier this cycle.
   always_comb begin
      w_mul_a = w_ae;
      w_mul_b = w_be;
      case (r_state)
         MUL1: begin
            w_mul_a = w_ao;
            w_mul_b = w_bo;
         end
         MUL2: begin
            w_mul_a = w_ae ^ w_ao;
            w_mul_b = w_be ^ w_bo;
         end
         default: begin
            w_mul_a = w_ae;
            w_mul_b = w_be;
         end
      endcase
   end

   clmul_half #(
      .W (HN)
   ) u_clmul_half (
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_mul_p)
   );

   // Pad P0, P1 (registered) and P2 (live in MUL2) to the recombine width.
   always_comb begin
      w_p0_ext          = '0;
      w_p1_ext          = '0;
      w_p2_ext          = '0;
      w_p0_ext[PN-1:0]  = r_p0;
      w_p1_ext[PN-1:0]  = r_p1;
      w_p2_ext[PN-1:0]  = w_mul_p;
   end

   assign w_y_full      = recombine(w_p0_ext, w_p1_ext, w_p2_ext, N);
   assign w_y_next      = w_y_full[2*N-2:0];
   // Padding bits above 2N-2 are always zero and intentionally dropped.
   assign w_unused_y_hi = ^w_y_full;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state, handshake outputs and register-enable decode.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_load       = 1'b0;
      w_cap_p0     = 1'b0;
      w_cap_p1     = 1'b0;
      w_cap_y      = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_load       = 1'b1;
               w_state_next = MUL0;
            end
         end
         MUL0: begin
            w_cap_p0     = 1'b1;
            w_state_next = MUL1;
         end
         MUL1: begin
            w_cap_p1     = 1'b1;
            w_state_next = MUL2;
         end
         MUL2: begin
            w_cap_y      = 1'b1;
            w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            // A new operand pair may be taken in the same cycle the result leaves.
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  w_load       = 1'b1;
                  w_state_next = MUL0;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Operand registers, loaded on an accepted input handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
      end else if (w_load) begin
         r_a <= a;
         r_b <= b;
      end
   end

   // Partial-product registers for P0 and P1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p0 <= '0;
         r_p1 <= '0;
      end else begin
         if (w_cap_p0) begin
            r_p0 <= w_mul_p;
         end
         if (w_cap_p1) begin
            r_p1 <= w_mul_p;
         end
      end
   end

   // Product register, updated only when leaving MUL2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y <= '0;
      end else if (w_cap_y) begin
         r_y <= w_y_next;
      end
   end

   assign y = r_y;

endmodule

// File: tb/tb_oka_seq_mult.sv
// Bench for oka_seq_mult: three instances (N=4, 8, 36) checked every cycle
// against a cycle-level handshake model and a shift-and-xor reference product.
module tb_oka_seq_mult;

   localparam int ND   = 3;
   localparam int WMAX = 36;
   localparam int YMAX = 2*WMAX - 1;
   localparam int QD   = 1024;

   logic               clk;
   logic               rst_s       [ND];
   logic               in_valid_s  [ND];
   logic               out_ready_s [ND];
   logic [WMAX-1:0]    a_s         [ND];
   logic [WMAX-1:0]    b_s         [ND];
   logic [ND-1:0]      in_ready_s;
   logic [ND-1:0]      out_valid_s;
   logic [6:0]         y4;
   logic [14:0]        y8;
   logic [70:0]        y36;
   logic [YMAX-1:0]    y_s         [ND];

   int n_tests = 0;
   int n_fail  = 0;

   assign y_s[0] = {{(YMAX-7){1'b0}}, y4};
   assign y_s[1] = {{(YMAX-15){1'b0}}, y8};
   assign y_s[2] = y36;

   oka_seq_mult #(.N(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst_s[0]),
      .in_valid  (in_valid_s[0]),
      .in_ready  (in_ready_s[0]),
      .a         (a_s[0][3:0]),
      .b         (b_s[0][3:0]),
      .out_valid (out_valid_s[0]),
      .out_ready (out_ready_s[0]),
      .y         (y4)
   );

   oka_seq_mult #(.N(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst_s[1]),
      .in_valid  (in_valid_s[1]),
      .in_ready  (in_ready_s[1]),
      .a         (a_s[1][7:0]),
      .b         (b_s[1][7:0]),
      .out_valid (out_valid_s[1]),
      .out_ready (out_ready_s[1]),
      .y         (y8)
   );

   oka_seq_mult #(.N(36)) u_dut36 (
      .clk       (clk),
      .rst       (rst_s[2]),
      .in_valid  (in_valid_s[2]),
      .in_ready  (in_ready_s[2]),
      .a         (a_s[2]),
      .b         (b_s[2]),
      .out_valid (out_valid_s[2]),
      .out_ready (out_ready_s[2]),
      .y         (y36)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int width_of(input int k);
      case (k)
         0:       return 4;
         1:       return 8;
         default: return 36;
      endcase
   endfunction

   function automatic logic [WMAX-1:0] mask_of(input int k);
      logic [WMAX-1:0] one;
      one = 1;
      return (one << width_of(k)) - one;
   endfunction

   // Reference carry-less product: xor of a shifted copy of x per set bit of z.
   function automatic logic [127:0] clmul_ref(input logic [63:0] x, input logic [63:0] z, input int n);
      logic [127:0] acc;
      acc = '0;
      for (int i = 0; i < n; i++) begin
         if (z[i]) acc = acc ^ ({64'b0, x} << i);
      end
      return acc;
   endfunction

   task automatic check(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d(N=%0d): got 0x%0h, expected 0x%0h", name, k, width_of(k), act, exp);
      end
   endtask

   // ---------------- model + compare process ----------------
   // Model: an accepted pair is busy for 3 edges, then presented until taken.
   logic            exp_ov  [ND];
   logic            prev_ov [ND];
   int              cnt_m   [ND];
   logic [YMAX-1:0] prev_y  [ND];
   logic [YMAX-1:0] exp_mem [ND][QD];
   int              wr_p    [ND];
   int              rd_p    [ND];
   int              n_out   [ND];
   logic            exp_ir;
   logic [127:0]    ref_v;

   initial begin
      for (int k = 0; k < ND; k++) begin
         exp_ov[k] = 1'b0; prev_ov[k] = 1'b0; cnt_m[k] = 0;
         prev_y[k] = '0; wr_p[k] = 0; rd_p[k] = 0; n_out[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < ND; k++) begin
            if (rst_s[k]) begin
               check("reset_out_valid", k, out_valid_s[k], 1'b0);
               check("reset_in_ready", k, in_ready_s[k], 1'b1);
               check("reset_y", k, y_s[k], '0);
               exp_ov[k] = 1'b0; prev_ov[k] = 1'b0; cnt_m[k] = 0;
               prev_y[k] = '0; wr_p[k] = rd_p[k];
            end else begin
               exp_ir = (!exp_ov[k] && cnt_m[k] == 0) || (exp_ov[k] && out_ready_s[k]);
               check("out_valid", k, out_valid_s[k], exp_ov[k]);
               check("in_ready", k, in_ready_s[k], exp_ir);
               if (!exp_ov[k] || prev_ov[k]) check("y_hold", k, y_s[k], prev_y[k]);
               if (exp_ov[k] && out_ready_s[k]) begin
                  if (rd_p[k] != wr_p[k]) begin
                     check("product", k, y_s[k], exp_mem[k][rd_p[k] % QD]);
                     rd_p[k]++;
                  end else begin
                     check("spurious_output", k, 1, 0);
                  end
                  n_out[k]++;
                  $display("[TB] dut%0d N=%0d txn %0d y=0x%0h", k, width_of(k), n_out[k], y_s[k]);
               end
               prev_ov[k] = exp_ov[k];
               prev_y[k]  = y_s[k];
               if (exp_ov[k] && out_ready_s[k]) exp_ov[k] = 1'b0;
               if (cnt_m[k] > 0) begin
                  cnt_m[k]--;
                  if (cnt_m[k] == 0) exp_ov[k] = 1'b1;
               end
               if (exp_ir && in_valid_s[k]) begin
                  ref_v = clmul_ref({28'b0, a_s[k] & mask_of(k)}, {28'b0, b_s[k] & mask_of(k)}, width_of(k));
                  exp_mem[k][wr_p[k] % QD] = ref_v[YMAX-1:0];
                  wr_p[k]++;
                  cnt_m[k] = 3;
               end
            end
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic send(input int k, input logic [WMAX-1:0] av, input logic [WMAX-1:0] bv);
      int guard;
      guard = 0;
      a_s[k] = av;
      b_s[k] = bv;
      in_valid_s[k] = 1'b1;
      @(negedge clk);
      while (!in_ready_s[k] && guard < 50) begin
         guard++;
         @(negedge clk);
      end
      check("accept_within_bound", k, in_ready_s[k], 1'b1);
      @(posedge clk);
      #1;
      in_valid_s[k] = 1'b0;
   endtask

   task automatic run_one(input int k, input logic [WMAX-1:0] av, input logic [WMAX-1:0] bv,
                          input logic [YMAX-1:0] lit, input string name);
      int edges;
      out_ready_s[k] = 1'b1;
      send(k, av, bv);
      edges = 0;
      while (!out_valid_s[k] && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check({name, "_latency"}, k, edges, 3);
      check({name, "_y"}, k, y_s[k], lit);
      @(posedge clk);
      #1;
   endtask

   task automatic run_rand(input int k, input int count);
      logic            done;
      logic [WMAX-1:0] m;
      logic [63:0]     ra;
      logic [63:0]     rb;
      int              guard;
      done = 1'b0;
      m = mask_of(k);
      fork
         begin
            for (int i = 0; i < count; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               ra = {$urandom, $urandom};
               rb = {$urandom, $urandom};
               send(k, ra[WMAX-1:0] & m, rb[WMAX-1:0] & m);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready_s[k] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready_s[k] = 1'b1;
      guard = 0;
      while (rd_p[k] != wr_p[k] && guard < 40) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("drain_pending", k, wr_p[k] - rd_p[k], 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int edges;
      for (int k = 0; k < ND; k++) begin
         rst_s[k] = 1'b1; in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0;
         a_s[k] = '0; b_s[k] = '0;
      end

      // Hand-computed values pinning the reference model itself.
      check("ref_1x1", 2, clmul_ref(64'h1, 64'h1, 36), 128'h1);
      check("ref_3x7", 0, clmul_ref(64'h3, 64'h7, 4), 128'h9);
      check("ref_FxF", 0, clmul_ref(64'hF, 64'hF, 4), 128'h55);
      check("ref_5x3", 0, clmul_ref(64'h5, 64'h3, 4), 128'hF);
      check("ref_msb", 2, clmul_ref(64'h8_0000_0000, 64'h8_0000_0000, 36), 128'h40_0000_0000_0000_0000);
      check("ref_ones36", 2, clmul_ref(64'hF_FFFF_FFFF, 64'hF_FFFF_FFFF, 36), 128'h55_5555_5555_5555_5555);

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++) rst_s[k] = 1'b0;
      @(posedge clk);
      #1;

      // Directed vectors with literal expectations.
      run_one(2, 36'h1, 36'h1, 71'h1, "n36_one");
      run_one(2, 36'h8_0000_0000, 36'h8_0000_0000, 71'h40_0000_0000_0000_0000, "n36_msb");
      run_one(2, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 71'h55_5555_5555_5555_5555, "n36_ones");
      run_one(0, 36'h3, 36'h7, 71'h9, "n4_3x7");
      run_one(0, 36'hF, 36'hF, 71'h55, "n4_FxF");
      run_one(0, 36'h5, 36'h3, 71'hF, "n4_5x3");
      run_one(1, 36'h80, 36'h81, 71'h4080, "n8_80x81");
      run_one(1, 36'hFF, 36'h03, 71'h101, "n8_FFx03");

      // Backpressure: result held for 10 cycles, then release with a new pair.
      out_ready_s[2] = 1'b0;
      send(2, 36'hF, 36'hF);
      edges = 0;
      while (!out_valid_s[2] && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("bp_latency", 2, edges, 3);
      check("bp_y", 2, y_s[2], 71'h55);
      repeat (10) begin
         @(posedge clk);
         #1;
         check("bp_y_stable", 2, y_s[2], 71'h55);
         check("bp_valid_held", 2, out_valid_s[2], 1'b1);
         check("bp_in_ready_low", 2, in_ready_s[2], 1'b0);
      end
      a_s[2] = 36'h3;
      b_s[2] = 36'h7;
      in_valid_s[2] = 1'b1;
      out_ready_s[2] = 1'b1;
      #1;
      check("bp_in_ready_follows", 2, in_ready_s[2], 1'b1);
      @(posedge clk);
      #1;
      in_valid_s[2] = 1'b0;
      check("bp_busy_after_accept", 2, in_ready_s[2], 1'b0);
      edges = 0;
      while (!out_valid_s[2] && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("bp_next_latency", 2, edges, 3);
      check("bp_next_y", 2, y_s[2], 71'h9);
      @(posedge clk);
      #1;

      // Reset asserted while MUL1 is in progress.
      out_ready_s[2] = 1'b1;
      send(2, 36'h5, 36'h3);
      @(posedge clk);
      #1;
      check("midrst_busy", 2, in_ready_s[2], 1'b0);
      rst_s[2] = 1'b1;
      #1;
      check("midrst_out_valid", 2, out_valid_s[2], 1'b0);
      check("midrst_y", 2, y_s[2], 71'h0);
      check("midrst_in_ready", 2, in_ready_s[2], 1'b1);
      @(posedge clk);
      #1;
      rst_s[2] = 1'b0;
      run_one(2, 36'h5, 36'h3, 71'hF, "post_rst");

      // Random regression on all three widths in parallel.
      fork
         run_rand(0, 300);
         run_rand(1, 300);
         run_rand(2, 300);
      join

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound for the whole run.
   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
